seq_shifter: RTL
================

Name: seq_shifter

Overview:
Multi-cycle iterative shift unit. It uses the same shiftop encoding as the combinational Shifter: 00 SRL, 01 SRA, 10 SLL.
- Accepts one operand, op and amount per start pulse, then shifts STEP bits per cycle until the amount is exhausted.
- Results are returned with a done pulse.
- Sits beside the datapath ALU as the area-cheap alternative shifter for multi-cycle execution; reuses the combinational Shifter's expected-value checks.

Parameters:
WIDTH, 32, operand/result width
AMTW, 5, shift-amount width (log2 WIDTH)
STEP, 1, bits shifted per SHIFT cycle; legal values 1, 2, 4

Ports:
clock  input  1  single clock, all state updates on rising edge
reset  input  1  synchronous, active-low; sampled on rising edge of clock
start  input  1  request strobe; accepted only when ready=1
in  input  WIDTH  operand, captured on accepted start
shiftop  input  2  00 SRL, 01 SRA, 10 SLL, 11 reserved (see Optional Feature)
shiftamt  input  AMTW  shift amount, captured on accepted start
ready  output  1  1 in IDLE or DONE
busy  output  1  1 in SHIFT only
done  output  1  one-cycle pulse, 1 in DONE only
result  output  WIDTH  working/result register; valid when done=1 and held until next accept

Behaviour:
- Reset (reset=0 at edge): state<=IDLE, result<=0, rem<=0, op<=00; ready=1, busy=0, done=0. Applies in any state; an in-flight shift is discarded with no done pulse.
- States:
  - IDLE: on start=1, result<=in, op<=shiftop, rem<=shiftamt, go to SHIFT.
  - SHIFT: if rem==0, go to DONE. Otherwise shift result by k=min(STEP,rem), rem<=rem-k, and stay in SHIFT.
  - DONE: done=1 for exactly one cycle. With start=1, accept as in IDLE and go to SHIFT (back-to-back). Otherwise go to IDLE.
- Shift rules, per SHIFT cycle:
  - SRL: zero-fill MSBs.
  - SRA: replicate the bit WIDTH-1 of the working register.
  - SLL: zero-fill LSBs.
  - Final result equals in>>shiftamt, in>>>shiftamt (signed) or in<<shiftamt respectively.
- Latency: start sampled at edge k; done=1 in the cycle after edge k+1+ceil(shiftamt/STEP).
  - amt=0: done after k+1.
  - amt=31, STEP=1: done after k+32.
- start while busy=1 is ignored; no queuing, captured operands unchanged.
- in/shiftop/shiftamt changing after accept have no effect.
- Op 11 without the feature: no shift performed; result=in, same latency as amt=0 (rem forced to 0 at accept).
- Last partial step: rem<STEP shifts by rem only, so it never overshoots.
- result is never X after reset; outputs are registered or decoded from the state register only.

Optional Feature:
SEQ_SHIFTER_ROTATE_EN
- Defined: shiftop 11 = rotate right. Bits leaving the LSB re-enter at the MSB each cycle. Final result equals (in>>amt)|(in<<(WIDTH-amt)); amt=0 gives in. Latency rules are identical to the other ops.
- Undefined: shiftop 11 is treated as a no-op, as described in Behaviour.

Test Plan:
- reset=0 for 2 cycles, then 1 -> ready=1, busy=0, done=0, result=0x00000000.
- SRL: in=0x80000000, amt=4, STEP=1 -> busy for 5 cycles, done after edge k+5, result=0x08000000. SRA with same inputs -> 0xF8000000.
- SLL: in=0x00000001, amt=31 -> result=0x80000000 at edge k+32. SRA: in=0x80000000, amt=31 -> 0xFFFFFFFF.
- amt=0, in=0xDEADBEEF, any op -> done after edge k+1, result=0xDEADBEEF. start pulsed mid-SHIFT with different in -> ignored, original result delivered. start held in DONE -> new accept, no IDLE cycle.
- reset=0 asserted during SHIFT of amt=20 -> next cycle IDLE, result=0, no done pulse. Then a fresh request completes correctly.
- With SEQ_SHIFTER_ROTATE_EN: op=11, in=0x00000001, amt=1 -> 0x80000000. With STEP=4: in=0x12345678, amt=8 -> 0x78123456 in 2 SHIFT steps.

Source files
------------

// File: rtl/seq_shifter.sv
`default_nettype none
// ============================================================================
// Module   : seq_shifter
// Purpose  : Multi-cycle iterative shifter. It accepts one operand, opcode
//            and amount per start strobe, then shifts the working register
//            by up to STEP bits per cycle until the amount is used up. The
//            result is reported with a one-cycle done pulse.
//            Opcodes: 00 SRL, 01 SRA, 10 SLL, 11 reserved / rotate-right.
// Optional : define SEQ_SHIFTER_ROTATE_EN to make opcode 11 a rotate right.
//            Without it, opcode 11 passes the operand through unchanged and
//            completes with the same latency as a zero-amount shift.
// Ports    : clock    - rising-edge clock
//            reset    - synchronous, active-low reset
//            start    - request strobe, accepted only while ready=1
//            in       - operand, captured on accept
//            shiftop  - opcode, captured on accept
//            shiftamt - shift amount, captured on accept
//            ready    - 1 in IDLE or DONE (a new request can be accepted)
//            busy     - 1 in SHIFT
//            done     - one-cycle pulse in DONE
//            result   - working/result register, valid while done=1 and
//                       held until the next accept
// Revision : 1.0 - initial release
// ============================================================================
module seq_shifter #(
  parameter int WIDTH = 32,
  parameter int AMTW  = 5,
  parameter int STEP  = 1    // bits per SHIFT cycle: 1, 2 or 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] in,
  input  logic [1:0]       shiftop,
  input  logic [AMTW-1:0]  shiftamt,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  // --------------------------------------------------------------------------
  // Encodings
  // --------------------------------------------------------------------------
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [1:0] OP_SRL = 2'b00;
  localparam logic [1:0] OP_SRA = 2'b01;
  localparam logic [1:0] OP_SLL = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  localparam logic [AMTW-1:0] STEP_AMT = AMTW'(STEP);

  // --------------------------------------------------------------------------
  // Declarations
  // --------------------------------------------------------------------------
  logic [1:0]       state;
  logic [1:0]       next_state;
  logic [1:0]       op;
  logic [AMTW-1:0]  rem;
  logic [AMTW-1:0]  step_k;
  logic [AMTW-1:0]  accept_rem;
  logic [WIDTH-1:0] shifted;
  logic             accept;

  // A request is taken only while the FSM advertises ready; a start seen
  // during SHIFT falls through without touching the captured operands.
  assign accept = start & ready;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (start) begin
          next_state = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // The zero check happens in SHIFT itself, so even amount 0 spends
        // one cycle here before DONE.
        if (rem == '0) begin
          next_state = ST_DONE;
        end
      end
      ST_DONE: begin
        // Holding start in DONE chains straight into the next job.
        next_state = start ? ST_SHIFT : ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: output decode (pure function of the state register)
  // --------------------------------------------------------------------------
  always_comb begin
    ready = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    case (state)
      ST_IDLE:  ready = 1'b1;
      ST_SHIFT: busy  = 1'b1;
      ST_DONE: begin
        ready = 1'b1;
        done  = 1'b1;
      end
      default:  ready = 1'b0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Step size: the last partial step shifts by the remainder only so the
  // total never overshoots the requested amount.
  // --------------------------------------------------------------------------
  always_comb begin
    step_k = (rem < STEP_AMT) ? rem : STEP_AMT;
  end

  // --------------------------------------------------------------------------
  // Amount captured at accept. Without the rotate option opcode 11 is a
  // pass-through, so its amount is forced to zero and it completes with the
  // zero-amount latency.
  // --------------------------------------------------------------------------
  always_comb begin
    accept_rem = shiftamt;
`ifdef SEQ_SHIFTER_ROTATE_EN
    accept_rem = shiftamt;
`else
    if (shiftop == OP_RSV) begin
      accept_rem = '0;
    end
`endif
  end

  // --------------------------------------------------------------------------
  // One shift step of the working register
  // --------------------------------------------------------------------------
  always_comb begin
    shifted = result;
    case (op)
      OP_SRL: shifted = result >> step_k;
      // Sign comes from the working register's MSB; it never changes under
      // SRA, so this matches a single arithmetic shift of the operand.
      OP_SRA: shifted = WIDTH'($signed(result) >>> step_k);
      OP_SLL: shifted = result << step_k;
`ifdef SEQ_SHIFTER_ROTATE_EN
      // Bits leaving the LSB end re-enter at the MSB. step_k is non-zero
      // whenever this value is consumed.
      OP_RSV: shifted = (result >> step_k) | (result << (WIDTH - int'(step_k)));
`else
      OP_RSV: shifted = result;
`endif
      default: shifted = result;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset) begin
      result <= '0;
      rem    <= '0;
      op     <= OP_SRL;
    end else if (accept) begin
      result <= in;
      op     <= shiftop;
      rem    <= accept_rem;
    end else if ((state == ST_SHIFT) && (rem != '0)) begin
      result <= shifted;
      rem    <= rem - step_k;
    end
  end

endmodule
`default_nettype wire
